data_mem_bridge: RTL and testbench
==================================

Name: data_mem_bridge

Overview:
- Sits between the core's MEM stage and the data memory port, and serves as the memory-facing end of the store byte-enable interface.
- Takes the unshifted store mask (0000/0001/0011/1111), address, write data and load funct3 from the MEM stage.
- Drives a req/gnt/rvalid memory port with word-aligned address, shifted byte lanes and replicated write data.
- Returns sign- or zero-extended load data and stalls the pipeline until each access completes.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ or RESP before the access is aborted (1..65535)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
core_addr_i  in  32  byte address from EX/MEM
core_wdata_i  in  32  store data, right-aligned
core_we_i  in  4  unshifted store mask: 0000 none, 0001 SB, 0011 SH, 1111 SW
core_re_i  in  1  load request
core_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes = LW
core_stall_o  out  1  freeze PC/IF/ID/EX/MEM registers
core_rdata_o  out  32  extended load data
core_misaligned_o  out  1  one-cycle pulse, access dropped
bus_err_o  out  1  sticky timeout flag
mem_req_o  out  1  request valid
mem_addr_o  out  32  {addr[31:2],2'b00}
mem_we_o  out  4  byte lanes; 0000 = read
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read word

Behaviour:
- Reset (async, any state): FSM=IDLE; all outputs 0. mem_req_o drops immediately, with no wait for the clock edge.
- Request is sampled only in IDLE: store if core_we_i!=0, else load if core_re_i. Store wins when both are asserted.
- Alignment rules:
  - SB/LB/LBU: any offset.
  - SH/LH/LHU: addr[0]=0.
  - SW/LW: addr[1:0]=00.
  - Illegal mask value (e.g. 0111): treated as SW.
  - Misaligned access: core_misaligned_o=1 for that IDLE cycle, no memory access, no stall, FSM stays IDLE.
- IDLE:
  - On a valid aligned request, core_stall_o=1 combinationally.
  - At the clock edge, latch address, lanes, data, funct3 and offset, then go to REQ.
- Lane and data rules:
  - mem_we_o = mask << addr[1:0], or 0000 for loads.
  - mem_wdata_o: SB = byte replicated x4; SH = halfword replicated x2; SW = unchanged.
- REQ:
  - mem_req_o=1; address, lanes and data held stable until mem_gnt_i.
  - Store with gnt: transaction complete, go to IDLE.
  - Load with gnt: go to RESP.
  - mem_rvalid_i in REQ is ignored.
- RESP:
  - mem_req_o=0. On mem_rvalid_i, select the byte or halfword by the latched offset, extend it (LB/LH sign, LBU/LHU zero), go to IDLE.
- Completion cycle:
  - core_stall_o=0 in the cycle of store-gnt or load-rvalid, so the core advances on that edge.
  - core_rdata_o shows the extended data combinationally in that cycle, then holds the registered copy until the next load completes.
  - No double issue: after the edge, IDLE sees the next instruction's inputs.
- Stall: core_stall_o = (IDLE & valid aligned request) | ((REQ | RESP) & ~completion).
- Timeout:
  - A counter clears on entry to REQ and counts every cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES without completion: abort to IDLE, core_stall_o=0 that cycle, bus_err_o set.
  - Aborted load returns core_rdata_o=0.
  - bus_err_o clears only on reset.
  - A late gnt or rvalid after abort is ignored in IDLE.
- mem_gnt_i or mem_rvalid_i arriving in IDLE is ignored.
- Latency: store = 1 + gnt wait cycles; load = 1 + gnt wait + rvalid wait cycles. With zero-wait memory, loads take 3 cycles and stores take 2.

Test Plan:
1. Reset asserted while in REQ -> mem_req_o=0 with no clock edge; every output 0; bus_err_o=0.
2. SB addr=0x1003, wdata=0x000000A5, gnt immediate -> mem_addr_o=0x1000, mem_we_o=1000, mem_wdata_o=0xA5A5A5A5; stall high 1 cycle.
3. LB addr=0x2002, mem_rdata_i=0x12F45678, rvalid 2 cycles after gnt -> core_rdata_o=0xFFFFFFF4; LBU same address -> 0x000000F4; LH addr 0x2002 -> 0x000012F4.
4. SH addr=0x3001 -> core_misaligned_o pulses 1 cycle, mem_req_o stays 0, no stall; LW addr=0x3002 -> same.
5. TIMEOUT_CYCLES=4, gnt never asserted -> mem_req_o high 4 cycles, then IDLE; bus_err_o=1 and sticky; a late gnt is ignored.
6. Back-to-back SW 0x4000 then LW 0x4000 with 1-cycle gnt delay -> two separate transactions, no duplicate req; load returns the stored word.

Source files
------------

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: MEM-stage to data-memory req/gnt/rvalid bridge.
// Ports: core_* (MEM stage side), mem_* (memory side), bus_err_o sticky timeout.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_we_i,
  input  logic        core_re_i,
  input  logic [2:0]  core_funct3_i,
  output logic        core_stall_o,
  output logic [31:0] core_rdata_o,
  output logic        core_misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        is_st, is_ld;
  logic        sz_b, sz_h;
  logic        mis, go;
  logic [3:0]  mask;
  logic [3:0]  lanes;
  logic [31:0] rep_wdata;
  logic [31:0] sh_w;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] ext;
  logic        tmo;
  logic        stall, req, mis_p;

  // Request decode; illegal store masks fall through to word size.
  always_comb begin
    is_st = |core_we_i;
    is_ld = ~is_st & core_re_i;
    if (is_st) begin
      sz_b = (core_we_i == 4'b0001);
      sz_h = (core_we_i == 4'b0011);
    end else begin
      sz_b = (core_funct3_i[1:0] == 2'b00);
      sz_h = (core_funct3_i[1:0] == 2'b01);
    end
    mis = (sz_h & core_addr_i[0])
        | (~sz_b & ~sz_h & (|core_addr_i[1:0]));
    go = (is_st | is_ld) & ~mis;
    if (sz_b) begin
      mask      = 4'b0001;
      rep_wdata = {4{core_wdata_i[7:0]}};
    end else if (sz_h) begin
      mask      = 4'b0011;
      rep_wdata = {2{core_wdata_i[15:0]}};
    end else begin
      mask      = 4'b1111;
      rep_wdata = core_wdata_i;
    end
    lanes = is_st ? (mask << core_addr_i[1:0]) : 4'b0000;
  end

  // Load lane select and extension from the latched offset.
  always_comb begin
    sh_w = mem_rdata_i >> {off_q, 3'b000};
    rd_b = sh_w[7:0];
    rd_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    unique case (funct3_q)
      3'b000:  ext = {{24{rd_b[7]}}, rd_b};
      3'b100:  ext = {24'b0, rd_b};
      3'b001:  ext = {{16{rd_h[15]}}, rd_h};
      3'b101:  ext = {16'b0, rd_h};
      default: ext = mem_rdata_i;
    endcase
  end

  assign tmo = (cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stall    = 1'b0;
    req      = 1'b0;
    mis_p    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mis_p = (is_st | is_ld) & mis;
        if (go) begin
          stall    = 1'b1;
          addr_d   = {core_addr_i[31:2], 2'b00};
          off_d    = core_addr_i[1:0];
          we_d     = lanes;
          wdata_d  = rep_wdata;
          funct3_d = core_funct3_i;
          cnt_d    = 16'd0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        req   = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt_i && (we_q != 4'b0000)) begin
          state_d = S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          if (we_q == 4'b0000) rdata_d = 32'd0;
        end else begin
          stall = 1'b1;
          if (mem_gnt_i) state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid_i) begin
          rdata_d = ext;
          state_d = S_IDLE;
        end else if (tmo) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Comb outputs are gated so every output reads 0 while reset is held.
  assign core_stall_o      = stall & rst_n;
  assign core_misaligned_o = mis_p & rst_n;
  assign core_rdata_o      = rdata_d;
  assign bus_err_o         = err_q;
  assign mem_req_o         = req;
  assign mem_addr_o        = addr_q;
  assign mem_we_o          = we_q;
  assign mem_wdata_o       = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed scoreboard bench for data_mem_bridge.
// Runs with TIMEOUT_CYCLES=4.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic [3:0]  core_we_i = '0;
  logic        core_re_i = 1'b0;
  logic [2:0]  core_funct3_i = '0;
  logic        core_stall_o;
  logic [31:0] core_rdata_o;
  logic        core_misaligned_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_addr_i       (core_addr_i),
    .core_wdata_i      (core_wdata_i),
    .core_we_i         (core_we_i),
    .core_re_i         (core_re_i),
    .core_funct3_i     (core_funct3_i),
    .core_stall_o      (core_stall_o),
    .core_rdata_o      (core_rdata_o),
    .core_misaligned_o (core_misaligned_o),
    .bus_err_o         (bus_err_o),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_we_o          (mem_we_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_gnt_i         (mem_gnt_i),
    .mem_rvalid_i      (mem_rvalid_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  int          vectors = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] bmem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_in();
    core_we_i     = '0;
    core_re_i     = 1'b0;
    core_addr_i   = '0;
    core_wdata_i  = '0;
    core_funct3_i = '0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chkb({tag, "_req"}, mem_req_o, 1'b0);
    chkb({tag, "_stall"}, core_stall_o, 1'b0);
    chkb({tag, "_mis"}, core_misaligned_o, 1'b0);
    chkb({tag, "_err"}, bus_err_o, 1'b0);
    chk({tag, "_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_we"}, {28'd0, mem_we_o}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_rdata"}, core_rdata_o, 32'd0);
  endtask

  // One complete access: IDLE cycle, gdly wait cycles then gnt,
  // and for loads rdly RESP cycles with rvalid on the last.
  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic re,
                        input logic [2:0] f3, input int gdly,
                        input int rdly, input logic [31:0] rword,
                        input exp_t e);
    exp_t        got;
    logic [31:0] w;
    got = '0;
    sb.push_back(e);
    core_addr_i   = a;
    core_wdata_i  = wd;
    core_we_i     = we;
    core_re_i     = re;
    core_funct3_i = f3;
    settle();
    chkb("idle_stall", core_stall_o, 1'b1);
    chkb("idle_no_req", mem_req_o, 1'b0);
    tick();
    for (int i = 0; i <= gdly; i++) begin
      mem_gnt_i = (i == gdly);
      settle();
      chkb("req_valid", mem_req_o, 1'b1);
      if (mem_gnt_i) begin
        chkb("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) got = sb.pop_front();
        chk("mem_addr", mem_addr_o, got.addr);
        chk("mem_we", {28'd0, mem_we_o}, {28'd0, got.we});
        if (we != 4'b0000) begin
          chk("mem_wdata", mem_wdata_o, got.wdata);
          chkb("st_done_stall", core_stall_o, 1'b0);
          if (!bmem.exists(mem_addr_o)) bmem[mem_addr_o] = 32'd0;
          w = bmem[mem_addr_o];
          for (int k = 0; k < 4; k++)
            if (mem_we_o[k]) w[8*k +: 8] = mem_wdata_o[8*k +: 8];
          bmem[mem_addr_o] = w;
        end else begin
          chkb("ld_gnt_stall", core_stall_o, 1'b1);
        end
      end else begin
        chkb("req_wait_stall", core_stall_o, 1'b1);
      end
      tick();
    end
    mem_gnt_i = 1'b0;
    if (we == 4'b0000) begin
      for (int j = 1; j <= rdly; j++) begin
        mem_rvalid_i = (j == rdly);
        mem_rdata_i  = rword;
        settle();
        chkb("resp_no_req", mem_req_o, 1'b0);
        if (mem_rvalid_i) begin
          chk("ld_data", core_rdata_o, got.rdata);
          chkb("ld_done_stall", core_stall_o, 1'b0);
        end else begin
          chkb("resp_wait_stall", core_stall_o, 1'b1);
        end
        tick();
      end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    #2;
    chk_all_zero("por");
    tick();
    tick();
    rst_n = 1'b1;

    // Reset while in REQ drops everything without a clock edge.
    core_we_i    = 4'b1111;
    core_addr_i  = 32'h7000;
    core_wdata_i = 32'h01020304;
    settle();
    tick();
    settle();
    chkb("t1_in_req", mem_req_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("t1_rst");
    idle_in();
    tick();
    rst_n = 1'b1;

    // SB at offset 3.
    access(32'h1003, 32'h000000A5, 4'b0001, 1'b0, 3'b000, 0, 0, 32'd0,
           '{32'h1000, 4'b1000, 32'hA5A5A5A5, 32'd0});
    // SH at offset 2.
    access(32'h3002, 32'h0000BEEF, 4'b0011, 1'b0, 3'b000, 0, 0, 32'd0,
           '{32'h3000, 4'b1100, 32'hBEEFBEEF, 32'd0});

    // Loads from 0x2002, rvalid two cycles after gnt.
    access(32'h2002, 32'd0, 4'b0000, 1'b1, 3'b000, 0, 2, 32'h12F45678,
           '{32'h2000, 4'b0000, 32'd0, 32'hFFFFFFF4});
    settle();
    chk("lb_hold", core_rdata_o, 32'hFFFFFFF4);
    tick();
    access(32'h2002, 32'd0, 4'b0000, 1'b1, 3'b100, 0, 2, 32'h12F45678,
           '{32'h2000, 4'b0000, 32'd0, 32'h000000F4});
    access(32'h2002, 32'd0, 4'b0000, 1'b1, 3'b001, 0, 2, 32'h12F45678,
           '{32'h2000, 4'b0000, 32'd0, 32'h000012F4});
    access(32'h2000, 32'd0, 4'b0000, 1'b1, 3'b001, 0, 1, 32'h12F48001,
           '{32'h2000, 4'b0000, 32'd0, 32'hFFFF8001});
    access(32'h2000, 32'd0, 4'b0000, 1'b1, 3'b101, 0, 1, 32'h12F48001,
           '{32'h2000, 4'b0000, 32'd0, 32'h00008001});

    // Misaligned SH and LW.
    core_we_i   = 4'b0011;
    core_addr_i = 32'h3001;
    settle();
    chkb("sh_mis", core_misaligned_o, 1'b1);
    chkb("sh_mis_stall", core_stall_o, 1'b0);
    chkb("sh_mis_req", mem_req_o, 1'b0);
    tick();
    idle_in();
    settle();
    chkb("sh_mis_pulse", core_misaligned_o, 1'b0);
    chkb("sh_mis_idle", mem_req_o, 1'b0);
    tick();
    core_re_i     = 1'b1;
    core_funct3_i = 3'b010;
    core_addr_i   = 32'h3002;
    settle();
    chkb("lw_mis", core_misaligned_o, 1'b1);
    chkb("lw_mis_stall", core_stall_o, 1'b0);
    tick();
    idle_in();
    settle();
    chkb("lw_mis_idle", mem_req_o, 1'b0);
    tick();

    // Back-to-back SW then LW of the same word.
    access(32'h4000, 32'hDEADBEEF, 4'b1111, 1'b0, 3'b000, 1, 0, 32'd0,
           '{32'h4000, 4'b1111, 32'hDEADBEEF, 32'd0});
    access(32'h4000, 32'd0, 4'b0000, 1'b1, 3'b010, 1, 1,
           bmem.exists(32'h4000) ? bmem[32'h4000] : 32'd0,
           '{32'h4000, 4'b0000, 32'd0, 32'hDEADBEEF});
    settle();
    chkb("b2b_sb_empty", sb.size() == 0, 1'b1);
    chkb("b2b_no_dup", mem_req_o, 1'b0);
    tick();

    // Store timeout with no gnt.
    core_we_i    = 4'b1111;
    core_addr_i  = 32'h5000;
    core_wdata_i = 32'h11223344;
    settle();
    chkb("to_idle_stall", core_stall_o, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      settle();
      chkb("to_req", mem_req_o, 1'b1);
      chkb("to_stall", core_stall_o, i != 3);
      chkb("to_err_pre", bus_err_o, 1'b0);
      tick();
    end
    settle();
    chkb("to_req_off", mem_req_o, 1'b0);
    chkb("to_err", bus_err_o, 1'b1);
    tick();
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    settle();
    chkb("late_gnt_req", mem_req_o, 1'b0);
    chkb("late_gnt_stall", core_stall_o, 1'b0);
    tick();
    idle_in();
    settle();
    chkb("late_gnt_idle", mem_req_o, 1'b0);
    chkb("err_sticky", bus_err_o, 1'b1);
    tick();

    // Load timeout returns zero data.
    core_re_i     = 1'b1;
    core_funct3_i = 3'b010;
    core_addr_i   = 32'h6000;
    settle();
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      settle();
      chkb("lto_req", mem_req_o, 1'b1);
      if (i == 3) chk("lto_rdata", core_rdata_o, 32'd0);
      tick();
    end
    settle();
    chk("lto_hold", core_rdata_o, 32'd0);
    chkb("lto_err", bus_err_o, 1'b1);
    tick();

    // Only reset clears the sticky error.
    rst_n = 1'b0;
    #1;
    chkb("err_rst", bus_err_o, 1'b0);
    tick();
    rst_n = 1'b1;
    settle();
    chkb("err_after_rst", bus_err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
